// File: rtl/cluster_event_fifo_reader_pkg.sv
// cluster_evt_fifo_pkg: shared definitions for the SoC->cluster event FIFO.
// Holds the default geometry agreed with the SoC-side writer, the pointer
// type, and width-generic gray/binary conversions.
// The conversions work on a 32-bit container. Callers zero-extend the input
// and truncate the result. Leading zeros do not disturb either transform,
// so the functions are correct for any pointer width up to 32.
package cluster_evt_fifo_pkg;

  localparam int DEF_LOG_DEPTH  = 3;
  localparam int DEF_EVNT_WIDTH = 8;

  // Pointer type for the default geometry: one extra MSB marks the wrap lap.
  typedef logic [DEF_LOG_DEPTH:0] evt_ptr_t;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/cluster_event_fifo_reader_if.sv
// cluster_event_fifo_reader_if: bus between the SoC-side FIFO writer/storage
// and the cluster-side reader, plus the event valid/ready stream.
//   async_wptr_i  gray write pointer (SoC domain)
//   async_data_i  writer-held buffer entries (SoC domain)
//   async_rptr_o  gray read pointer returned to the writer
//   evt_valid_o / evt_data_o / evt_ready_i  event stream to the consumer
// Signal suffixes are relative to the reader.
// Modports:
//   master  the reader side
//   slave   the writer/consumer side
interface cluster_event_fifo_reader_if
  import cluster_evt_fifo_pkg::*;
#(
  parameter int LOG_DEPTH  = DEF_LOG_DEPTH,
  parameter int EVNT_WIDTH = DEF_EVNT_WIDTH
);
  logic [LOG_DEPTH:0]                           async_wptr_i;
  logic [2**LOG_DEPTH-1:0][EVNT_WIDTH-1:0]      async_data_i;
  logic [LOG_DEPTH:0]                           async_rptr_o;
  logic                                         evt_valid_o;
  logic [EVNT_WIDTH-1:0]                        evt_data_o;
  logic                                         evt_ready_i;

  modport master (
    input  async_wptr_i, async_data_i, evt_ready_i,
    output async_rptr_o, evt_valid_o, evt_data_o
  );

  modport slave (
    output async_wptr_i, async_data_i, evt_ready_i,
    input  async_rptr_o, evt_valid_o, evt_data_o
  );
endinterface

// File: rtl/cluster_event_fifo_reader_sync.sv
// evt_ptr_sync: SYNC_STAGES-deep flop chain that brings a gray-coded pointer
// into the local clock domain. Reset is synchronous and active-high.
//   clk_i, rst_i  clock / reset
//   async_i       pointer from the foreign domain
//   sync_o        synchronized pointer (last stage)
// SYNC_STAGES must be at least 2.
module evt_ptr_sync #(
  parameter int W           = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] sync_o
);
  logic [SYNC_STAGES-1:0][W-1:0] stg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stg <= '0;
    end else begin
      stg[0] <= async_i;
      for (int i = 1; i < SYNC_STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign sync_o = stg[SYNC_STAGES-1];
endmodule

// File: rtl/cluster_event_fifo_reader.sv
// cluster_event_fifo_reader: cluster-side read endpoint of the SoC->cluster
// event dual-clock FIFO. It performs four jobs:
//   - synchronizes the writer's gray pointer,
//   - detects non-empty,
//   - pops entries into a registered valid/ready output stage,
//   - returns its own gray read pointer.
// Ports:
//   clk_i, rst_i  cluster clock; synchronous active-high reset
//   bus           cluster_event_fifo_reader_if.master (pointers, data, event stream)
//   fill_level_o  entries still in the buffer (optional)
// Optional feature: `define CLUSTER_EVT_FIFO_FILL_LEVEL_EN adds the
// registered fill_level_o output. When it is undefined, the port and its
// logic do not exist.
module cluster_event_fifo_reader
  import cluster_evt_fifo_pkg::*;
#(
  parameter int LOG_DEPTH   = DEF_LOG_DEPTH,
  parameter int EVNT_WIDTH  = DEF_EVNT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  cluster_event_fifo_reader_if.master  bus
`ifdef CLUSTER_EVT_FIFO_FILL_LEVEL_EN
  ,
  output logic [LOG_DEPTH:0]           fill_level_o
`endif
);
  localparam int PW = LOG_DEPTH + 1;

  logic [PW-1:0] wptr_sync, wptr_bin, rptr_bin, rptr_nxt;
  logic          empty, pop;

  evt_ptr_sync #(.W(PW), .SYNC_STAGES(SYNC_STAGES)) u_wptr_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (bus.async_wptr_i),
    .sync_o  (wptr_sync)
  );

  assign wptr_bin = PW'(gray2bin(32'(wptr_sync)));
  // Compare at full width. The MSB separates laps, so equality means empty.
  assign empty    = (wptr_bin == rptr_bin);
  // Refill the output register when it is free or is being drained now.
  assign pop      = !empty && (!bus.evt_valid_o || bus.evt_ready_i);
  assign rptr_nxt = rptr_bin + PW'(1);

  // The slot is handed back to the writer at pop time. Its word has already
  // been copied into evt_data_o, so the writer may overwrite the slot.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rptr_bin         <= '0;
      bus.async_rptr_o <= '0;
      bus.evt_valid_o  <= 1'b0;
      bus.evt_data_o   <= '0;
    end else if (pop) begin
      bus.evt_data_o   <= bus.async_data_i[rptr_bin[LOG_DEPTH-1:0]];
      bus.evt_valid_o  <= 1'b1;
      rptr_bin         <= rptr_nxt;
      bus.async_rptr_o <= PW'(bin2gray(32'(rptr_nxt)));
    end else if (bus.evt_ready_i && bus.evt_valid_o) begin
      bus.evt_valid_o  <= 1'b0;
    end
  end

`ifdef CLUSTER_EVT_FIFO_FILL_LEVEL_EN
  // Counts against the post-edge read pointer, so the word just moved into
  // the output register is not counted.
  always_ff @(posedge clk_i) begin
    if (rst_i) fill_level_o <= '0;
    else       fill_level_o <= wptr_bin - (pop ? rptr_nxt : rptr_bin);
  end
`endif
endmodule

// File: tb/tb_cluster_event_fifo_reader.sv
// Self-checking bench for cluster_event_fifo_reader. It runs a directed
// per-cycle table, hand-written burst and reset sequences, and random
// streams checked against a queue-based model of the writer and consumer.
module tb_cluster_event_fifo_reader;
  localparam int LD    = 3;
  localparam int EW    = 8;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cluster_event_fifo_reader_if #(.LOG_DEPTH(LD), .EVNT_WIDTH(EW)) bus ();
`ifdef CLUSTER_EVT_FIFO_FILL_LEVEL_EN
  logic [LD:0] fill_level;
`endif

  cluster_event_fifo_reader #(.LOG_DEPTH(LD), .EVNT_WIDTH(EW), .SYNC_STAGES(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef CLUSTER_EVT_FIFO_FILL_LEVEL_EN
    ,
    .fill_level_o (fill_level)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int unsigned wb = 0;  // writer's binary write count

  typedef struct {
    bit         rst;
    bit         push;
    logic [7:0] wdata;
    bit         ready;
    bit         exp_valid;
    logic [7:0] exp_data;
    logic [3:0] exp_rptr;
  } step_t;

  step_t tbl [13];

  function automatic step_t mk(bit r, bit p, logic [7:0] w, bit rdy, bit v, logic [7:0] d, logic [3:0] rp);
    step_t s;
    s.rst = r; s.push = p; s.wdata = w; s.ready = rdy;
    s.exp_valid = v; s.exp_data = d; s.exp_rptr = rp;
    return s;
  endfunction

  function automatic logic [3:0] gray(int unsigned x);
    logic [3:0] b;
    b = 4'(x);
    return b ^ (b >> 1);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(logic [7:0] w);
    bus.async_data_i[3'(wb % DEPTH)] = w;
    wb++;
    bus.async_wptr_i = gray(wb);
  endtask

  // Resets the DUT and the bench writer in the same window.
  task automatic do_reset();
    rst = 1'b1;
    wb = 0;
    bus.async_wptr_i = '0;
    bus.evt_ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_valid", 32'(bus.evt_valid_o), 0);
    check("reset_rptr", 32'(bus.async_rptr_o), 0);
    rst = 1'b0;
  endtask

  // Random writer and consumer driving n events through the block. The model
  // is a FIFO queue of written words; the read pointer must equal gray(words
  // taken from the buffer so far).
  task automatic run_stream(int n_events, int ready_pct, string tag);
    logic [7:0] q[$];
    int consumed = 0, pushed = 0, popped;
    bit prev_valid = 0, prev_ready = 0;
    logic [7:0] prev_data = '0;
    logic [3:0] prev_rptr = '0;
    logic [7:0] w;
    bit rdy;
    int cyc = 0;
    while (consumed < n_events && cyc < 20000) begin
      popped = consumed + int'(bus.evt_valid_o);
      check({tag, "_rptr"}, 32'(bus.async_rptr_o), 32'(gray(popped)));
      if (cyc > 0)
        check({tag, "_rptr_step"}, 32'($countones(bus.async_rptr_o ^ prev_rptr) <= 1), 1);
      if (prev_valid && !prev_ready) begin
        check({tag, "_hold_valid"}, 32'(bus.evt_valid_o), 1);
        check({tag, "_hold_data"}, 32'(bus.evt_data_o), 32'(prev_data));
      end
      rdy = ($urandom_range(99) < ready_pct);
      bus.evt_ready_i = rdy;
      if (bus.evt_valid_o && rdy) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL %s_spurious actual=%0h required=none", tag, bus.evt_data_o);
        end else begin
          check({tag, "_data"}, 32'(bus.evt_data_o), 32'(q.pop_front()));
        end
        consumed++;
      end
      if (pushed < n_events && (int'(wb) - popped) < DEPTH && $urandom_range(1) == 1) begin
        w = 8'($urandom);
        push(w);
        q.push_back(w);
        pushed++;
      end
      prev_valid = bus.evt_valid_o;
      prev_ready = rdy;
      prev_data  = bus.evt_data_o;
      prev_rptr  = bus.async_rptr_o;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done"}, 32'(consumed), 32'(n_events));
  endtask

  initial begin
    int seen, first, last, waited;

    tbl[0]  = mk(1, 0, 8'h00, 1, 0, 8'h00, 4'b0000);
    tbl[1]  = mk(1, 0, 8'h00, 1, 0, 8'h00, 4'b0000);
    tbl[2]  = mk(0, 1, 8'hA5, 1, 0, 8'h00, 4'b0000);
    tbl[3]  = mk(0, 0, 8'h00, 1, 0, 8'h00, 4'b0000);
    tbl[4]  = mk(0, 0, 8'h00, 1, 1, 8'hA5, 4'b0001);
    tbl[5]  = mk(0, 0, 8'h00, 1, 0, 8'hA5, 4'b0001);
    tbl[6]  = mk(0, 1, 8'h31, 0, 0, 8'hA5, 4'b0001);
    tbl[7]  = mk(0, 1, 8'h32, 0, 0, 8'hA5, 4'b0001);
    tbl[8]  = mk(0, 0, 8'h00, 0, 1, 8'h31, 4'b0011);
    tbl[9]  = mk(0, 0, 8'h00, 0, 1, 8'h31, 4'b0011);
    tbl[10] = mk(0, 0, 8'h00, 0, 1, 8'h31, 4'b0011);
    tbl[11] = mk(0, 0, 8'h00, 1, 1, 8'h32, 4'b0010);
    tbl[12] = mk(0, 0, 8'h00, 1, 0, 8'h32, 4'b0010);

    bus.async_data_i = {$urandom, $urandom};
    bus.async_wptr_i = '0;
    bus.evt_ready_i  = 1'b1;
    @(negedge clk);

    // Directed table: reset, single event latency, backpressure
    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rst;
      bus.evt_ready_i = tbl[i].ready;
      if (tbl[i].push) push(tbl[i].wdata);
      @(negedge clk);
      check($sformatf("step%0d_valid", i), 32'(bus.evt_valid_o), 32'(tbl[i].exp_valid));
      check($sformatf("step%0d_data", i), 32'(bus.evt_data_o), 32'(tbl[i].exp_data));
      check($sformatf("step%0d_rptr", i), 32'(bus.async_rptr_o), 32'(tbl[i].exp_rptr));
    end

`ifdef CLUSTER_EVT_FIFO_FILL_LEVEL_EN
    do_reset();
    check("reset_fill", 32'(fill_level), 0);
`endif

    // Full burst: 8 entries stepped one per cycle, always ready
    do_reset();
    seen = 0; first = -1; last = -1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (bus.evt_valid_o) begin
        check($sformatf("burst_data%0d", seen), 32'(bus.evt_data_o), 32'(8'h10 + seen));
        if (first < 0) first = cyc;
        last = cyc;
        seen++;
      end
      if (cyc < 8) push(8'(8'h10 + cyc));
      @(negedge clk);
    end
    check("burst_count", 32'(seen), 8);
    check("burst_first_latency", 32'(first), 3);
    check("burst_contiguous", 32'(last - first), 7);
    check("burst_rptr_end", 32'(bus.async_rptr_o), 32'(4'b1100));

    // Reset mid-burst with entries still pending
    do_reset();
    bus.evt_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'h60 + i));
    waited = 0;
    while (!bus.evt_valid_o && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("midrst_valid_seen", 32'(bus.evt_valid_o), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    wb = 0;
    bus.async_wptr_i = '0;
    @(negedge clk);
    check("midrst_valid", 32'(bus.evt_valid_o), 0);
    check("midrst_rptr", 32'(bus.async_rptr_o), 0);
`ifdef CLUSTER_EVT_FIFO_FILL_LEVEL_EN
    check("midrst_fill", 32'(fill_level), 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Wrap-around with the consumer always ready, then random streams
    do_reset();
    run_stream(20, 100, "wrap");
    do_reset();
    run_stream(300, 60, "rand60");
    do_reset();
    run_stream(300, 25, "rand25");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
